alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 30 +++
 rtl/alu_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// aluop codes and the arbiter FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_ADDS = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_OP_MAX = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: wrap-around add/sub, bitwise ops and signed set-less-than.
// Opcodes above ALU_OP_MAX give a zero result with err raised.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] c,
    output logic             err
);

    always_comb begin
        c   = '0;
        err = 1'b0;
        case (op)
            ALU_ADD:  c = a + b;
            ALU_SUB:  c = a - b;
            ALU_ADDS: c = a + b;
            ALU_AND:  c = a & b;
            ALU_OR:   c = a | b;
            ALU_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  err = (op > ALU_OP_MAX);
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// A granted op is latched, executed for one cycle, and its result held until accepted.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the round-robin winner
// EXEC  | ALU driven from latched operands; result captured at end of cycle
// RESP  | result presented to the owner until its resp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_c,
    output logic             resp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_c,
    output logic             resp1_err,
    output logic             busy
);

    arb_state_t       state_q, state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [OPW-1:0]   op_q;
    logic             err_q;
    logic [WIDTH-1:0] alu_c;
    logic             alu_err;

    logic grant_any, grant_id, accept, resp_fire;

    // With both requesting, the one not served last wins.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign accept    = (state_q == IDLE) && grant_any;
    assign resp_fire = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);

    alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .c   (alu_c),
        .err (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = accept && !grant_id;
        req1_ready  = accept && grant_id;
        resp0_valid = (state_q == RESP) && !owner_q;
        resp1_valid = (state_q == RESP) && owner_q;
        resp0_c     = resp0_valid ? c_q : '0;
        resp1_c     = resp1_valid ? c_q : '0;
        resp0_err   = resp0_valid && err_q;
        resp1_err   = resp1_valid && err_q;
        busy        = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            c_q          <= '0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
                a_q          <= grant_id ? req1_a  : req0_a;
                b_q          <= grant_id ? req1_b  : req0_b;
                op_q         <= grant_id ? req1_op : req0_op;
            end
            if (state_q == EXEC) begin
                c_q   <= alu_c;
                err_q <= alu_err;
            end
        end
    end

endmodule
